// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int SUB_N = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses between a
// controller (master) and the serial subtractor (slave).
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int N = SUB_N
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         Bout;

  modport master (
    output start, a, b, Bin,
    input  busy, done, diff, Bout
  );

  modport slave (
    input  start, a, b, Bin,
    output busy, done, diff, Bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // A borrow leaves the cell when b exceeds a, or when they match and a
  // borrow came in.
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one LSB-first bit step per clock, result and
// final borrow registered at the end of the run and held until the next one.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int N     = SUB_N,
  localparam int CNT_W = $clog2(N) + 1
) (
  input logic                 clk,
  input logic                 rst,
  serial_subtractor_if.slave  bus
);

  state_e           state_q;
  logic [N-1:0]     aSr_q;
  logic [N-1:0]     bSr_q;
  logic [N-1:0]     resSr_q;
  logic [N-1:0]     resSr_d;
  logic             brw_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic bitD;
  logic brwNext;

  full_subtractor u_cell (
    .a_i    (aSr_q[0]),
    .b_i    (bSr_q[0]),
    .bin_i  (brw_q),
    .d_o    (bitD),
    .bout_o (brwNext)
  );

  // Result bits arrive LSB first, so each new bit enters at the MSB.
  assign resSr_d = {bitD, resSr_q[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      resSr_q <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            aSr_q   <= bus.a;
            bSr_q   <= bus.b;
            brw_q   <= bus.Bin;
            resSr_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          aSr_q   <= aSr_q >> 1;
          bSr_q   <= bSr_q >> 1;
          resSr_q <= resSr_d;
          brw_q   <= brwNext;
          cnt_q   <= cnt_q + CNT_W'(1);
          // The Nth bit step publishes the result; diff/Bout hold otherwise.
          if (cnt_q == CNT_W'(N - 1)) begin
            diff_q  <= resSr_d;
            bout_q  <= brwNext;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the serial subtractor: latency, handshake,
// reset abort, wrap-around and the adder round-trip property.
module tb_serial_subtractor;

  localparam int N       = 8;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] prevDiff = '0;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle from IDLE and waits (bounded) for done.
  // Samples are taken on the negedge; sample 1 is the first after acceptance.
  task automatic applyStimulus(input logic [N-1:0] aIn, input logic [N-1:0] bIn,
                               input logic binIn, output int latency,
                               output int busyCycles, output logic busyAfter,
                               output logic [N-1:0] diffEarly);
    int cyc;
    bus.start = 1'b1;
    bus.a     = aIn;
    bus.b     = bIn;
    bus.Bin   = binIn;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.a      = N'($urandom);
    bus.b      = N'($urandom);
    bus.Bin    = 1'($urandom);
    diffEarly  = bus.diff;
    cyc        = 1;
    busyCycles = bus.busy ? 1 : 0;
    while (!bus.done && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busyCycles++;
    end
    latency = bus.done ? cyc : -1;
    @(negedge clk);
    busyAfter = bus.busy;
  endtask

  task automatic runOp(input string tag, input logic [N-1:0] aIn,
                       input logic [N-1:0] bIn, input logic binIn,
                       input logic [N-1:0] expDiff, input logic expBout);
    int lat, bc;
    logic ba;
    logic [N-1:0] de;
    applyStimulus(aIn, bIn, binIn, lat, bc, ba, de);
    checkOutput({tag, " latency"}, 32'(lat), 32'd9);
    checkOutput({tag, " heldDiff"}, 32'(de), 32'(prevDiff));
    checkOutput({tag, " diff"}, 32'(bus.diff), 32'(expDiff));
    checkOutput({tag, " Bout"}, 32'(bus.Bout), 32'(expBout));
    checkOutput({tag, " idleAfter"}, 32'(ba), 32'd0);
    prevDiff = expDiff;
  endtask

  initial begin
    int lat, bc, doneCount;
    logic ba;
    logic [N-1:0] de, ra, rb, expD;
    logic rbin, expB;
    logic [N:0] wide;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.Bin   = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst done", 32'(bus.done), 32'd0);
    checkOutput("rst diff", 32'(bus.diff), 32'd0);
    checkOutput("rst Bout", 32'(bus.Bout), 32'd0);

    // Basic op with latency and busy window
    applyStimulus(8'h1E, 8'h0A, 1'b0, lat, bc, ba, de);
    checkOutput("op1 latency", 32'(lat), 32'd9);
    checkOutput("op1 busyCycles", 32'(bc), 32'd9);
    checkOutput("op1 busyAfter", 32'(ba), 32'd0);
    checkOutput("op1 diff", 32'(bus.diff), 32'h14);
    checkOutput("op1 Bout", 32'(bus.Bout), 32'd0);
    checkOutput("op1 doneLow", 32'(bus.done), 32'd0);
    prevDiff = 8'h14;

    runOp("negative", 8'h0A, 8'h14, 1'b0, 8'hF6, 1'b1);
    runOp("wrapBin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    runOp("msbBorrow", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    runOp("equal", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

    // start held high through RUN and DONE must yield a single operation
    bus.start = 1'b1;
    bus.a     = 8'h32;
    bus.b     = 8'h0A;
    bus.Bin   = 1'b0;
    @(negedge clk);
    bus.a     = 8'h55;
    doneCount = 0;
    for (int i = 1; i <= 9; i++) begin
      if (bus.done) doneCount++;
      if (i < 9) @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("held doneCount", 32'(doneCount), 32'd1);
    checkOutput("held diff", 32'(bus.diff), 32'h28);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkOutput("held noRestart busy", 32'(bus.busy), 32'd0);
    checkOutput("held doneTotal", 32'(doneCount), 32'd1);
    prevDiff = 8'h28;

    // Reset four cycles into RUN aborts the operation
    bus.start = 1'b1;
    bus.a     = 8'h50;
    bus.b     = 8'h10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort diff", 32'(bus.diff), 32'd0);
    checkOutput("abort Bout", 32'(bus.Bout), 32'd0);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkOutput("abort noDone", 32'(doneCount), 32'd0);
    prevDiff = '0;
    runOp("afterAbort", 8'h3C, 8'h14, 1'b0, 8'h28, 1'b0);

    // Simultaneous rst and start: stays idle
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    checkOutput("rstStart busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("rstStart stillIdle", 32'(bus.busy), 32'd0);
    prevDiff = '0;

    // Random ops against modular arithmetic and the adder round trip
    for (int i = 0; i < 200; i++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      rbin = 1'($urandom);
      wide = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rbin};
      expD = wide[N-1:0];
      expB = ({1'b0, ra} < ({1'b0, rb} + {{N{1'b0}}, rbin}));
      applyStimulus(ra, rb, rbin, lat, bc, ba, de);
      checkOutput("rand latency", 32'(lat), 32'd9);
      checkOutput("rand diff", 32'(bus.diff), 32'(expD));
      checkOutput("rand Bout", 32'(bus.Bout), 32'(expB));
      checkOutput("rand adderRoundTrip", 32'(N'(bus.diff + rb + N'(rbin))), 32'(ra));
      checkOutput("rand heldDiff", 32'(de), 32'(prevDiff));
      prevDiff = expD;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - Bin, one bit per clock, LSB first. Also reports the final borrow-out.
- It is the inverse-operation companion to the team's combinational N-bit ripple adder.
- Used where area matters more than latency, and as a cross-check engine: adder result minus operand must return the other operand.
- Simple start/busy/done handshake toward a controller or bench.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- CNT_W, $clog2(N)+1, width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin. Sampled only in IDLE.
- a  input  N  minuend. Sampled on the edge that accepts start.
- b  input  N  subtrahend. Sampled on the edge that accepts start.
- Bin  input  1  borrow-in. Sampled on the edge that accepts start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; high only in DONE.
- diff  output  N  result. Valid from done onward; held until the next accepted start.
- Bout  output  1  final borrow-out. Valid and held like diff.

Behaviour:
- Reset: rst sampled high on a clk edge forces state IDLE, busy=0, done=0, diff=0, Bout=0, counter=0, shift registers=0. rst overrides all other inputs. Asserting rst mid-operation aborts it; no done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a start=1 edge: load a_sr<=a, b_sr<=b, brw<=Bin, res_sr<=0, cnt<=0, go to RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Bit step on the LSBs: d = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
  - a_sr and b_sr shift right by one.
  - res_sr shifts right with d inserted at the MSB.
  - cnt increments.
  - On the edge where cnt==N-1 (the Nth bit step): diff<=final res_sr value, Bout<=brw_next, go to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency: start accepted at edge E0 → bit steps at E1..EN → done high in the cycle following EN → IDLE after EN+1. The next start can be accepted at EN+2 at the earliest. Throughput is one operation per N+2 cycles.
- start while busy (RUN or DONE) is ignored and is not queued. a, b and Bin may change freely after the accepting edge.
- Arithmetic:
  - Modulo 2^N: diff = (a - b - Bin) mod 2^N.
  - Bout = 1 iff a < b + Bin, treating all values as unsigned.
  - Wrap-around is legal and not an error.
- diff and Bout change only on the EN edge or on reset. They are stable in IDLE, and the prior result stays visible during a new RUN until that run's EN edge.
- Simultaneous rst and start: rst wins; state stays IDLE.

Decomposition:
- Shared package/include serial_sub_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default width constant SUB_N=8.
- One natural sub-module: full_subtractor. Combinational 1-bit cell, ports a, b, bin → d, bout. It is instantiated once for the bit step.
- The FSM, counter and shift registers stay in the top module.

Test Plan (N=8):
- a=0x1E, b=0x0A, Bin=0, start pulse → done exactly 9 cycles after the accepting edge, diff=0x14, Bout=0. busy is high for 9 cycles.
- a=0x0A, b=0x14, Bin=0 → diff=0xF6, Bout=1. Also a=0x00, b=0x00, Bin=1 → diff=0xFF, Bout=1 (wrap-around).
- a=0x80, b=0x01, Bin=0 → diff=0x7F, Bout=0. Then a=0xFF, b=0xFF, Bin=0 → diff=0x00, Bout=0.
- Start accepted with a=0x32, b=0x0A. Hold start high through RUN with a=0x55 on the inputs → only one done; diff=0x28. The next op starts only from IDLE.
- rst asserted 4 cycles into RUN → next cycle busy=0, done=0, diff=0, Bout=0; no done pulse afterwards. A fresh op (0x3C - 0x14) then gives diff=0x28.
- Randomized: 200 ops with random a, b, Bin, checked against (a - b - Bin) mod 256 and against the N-bit adder (diff + b + Bin == a mod 256).
